east_forward: RTL and testbench

- Eastward X-dimension forwarding stage of a mesh router; sits directly downstream of the local-injection splitter's east buffer.
- Arbitrates round-robin between the local east buffer and the buffer fed by the west neighbour's east link.
- Decrements dx and forwards packets east, or turns them onto the north/south Y-links once dx reaches 0.
- Emits registered write strobes into the downstream buffers.

---
 rtl/router_pkg.sv | 43 ++++
 rtl/rr_arbiter2.sv | 47 ++++
 rtl/east_forward.sv | 149 ++++++++++++++
 tb/tb_east_forward.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: packet field bounds, destination/source
// encodings and the dx/dy route decode used by every forwarding stage.
package router_pkg;

  localparam int unsigned PACKET_WIDTH = 30;
  localparam int unsigned DX_MSB       = 29;
  localparam int unsigned DX_LSB       = 21;
  localparam int unsigned DY_MSB       = 20;
  localparam int unsigned DY_LSB       = 12;

  localparam int unsigned DX_W = DX_MSB - DX_LSB + 1;
  localparam int unsigned DY_W = DY_MSB - DY_LSB + 1;

  typedef enum logic [1:0] {
    DST_EAST,
    DST_NORTH,
    DST_SOUTH,
    DST_DROP
  } dest_e;

  typedef enum logic {
    SRC_LOCAL,
    SRC_WEST
  } src_e;

  // Route decode for an eastward stage. dy == 0 goes NORTH; the Y stage
  // recognises it as arrived and delivers locally.
  function automatic dest_e dest_decode(input logic [DX_W-1:0] dx,
                                        input logic [DY_W-1:0] dy);
    dest_e d;
    if (dx[DX_W-1]) begin
      d = DST_DROP;
    end else if (dx != '0) begin
      d = DST_EAST;
    end else if (dy[DY_W-1]) begin
      d = DST_SOUTH;
    end else begin
      d = DST_NORTH;
    end
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset; last grant becomes WEST so that
//             LOCAL wins the first tie
//   req_i   : request vector, bit 0 = LOCAL, bit 1 = WEST
//   gnt_o   : one-hot (or zero) combinational grant
module rr_arbiter2
  import router_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  src_e last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: favour the source that did not win last time.
      2'b11:   gnt_o = (last_q == SRC_WEST) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // History only moves on an actual grant.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = SRC_LOCAL;
    end else if (gnt_o[1]) begin
      last_d = SRC_WEST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= SRC_WEST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/east_forward.sv
// Eastward X-dimension forwarding stage of a mesh router.
// Pops packets from the local east buffer or the west-link buffer (both
// first-word-fall-through), decrements dx and forwards east, or turns the
// packet north/south when dx == 0, or drops it when dx < 0.
//   clk, reset                 : clock and synchronous active-high reset
//   local_dout/empty/ren       : local east buffer head, empty flag, pop
//   west_dout/empty/ren        : west-link buffer head, empty flag, pop
//   east/north/south_dout/wen  : registered packet and write strobe
//   east/north/south_full      : downstream buffer full flags
//   err_drop                   : one-cycle pulse after a packet is discarded
//   drop_count                 : saturating count of discarded packets
module east_forward
  import router_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] local_dout,
  input  logic                    local_empty,
  output logic                    local_ren,
  input  logic [PACKET_WIDTH-1:0] west_dout,
  input  logic                    west_empty,
  output logic                    west_ren,
  output logic [PACKET_WIDTH-1:0] east_dout,
  output logic                    east_wen,
  input  logic                    east_full,
  output logic [PACKET_WIDTH-1:0] north_dout,
  output logic                    north_wen,
  input  logic                    north_full,
  output logic [PACKET_WIDTH-1:0] south_dout,
  output logic                    south_wen,
  input  logic                    south_full,
  output logic                    err_drop,
  output logic [7:0]              drop_count
);

  logic [PACKET_WIDTH-1:0] east_dout_q, east_dout_d;
  logic [PACKET_WIDTH-1:0] north_dout_q, north_dout_d;
  logic [PACKET_WIDTH-1:0] south_dout_q, south_dout_d;
  logic                    east_wen_q, east_wen_d;
  logic                    north_wen_q, north_wen_d;
  logic                    south_wen_q, south_wen_d;
  logic                    err_drop_q, err_drop_d;
  logic [7:0]              drop_count_q, drop_count_d;

  dest_e local_dst, west_dst, sel_dst;
  logic  local_avail, west_avail;
  logic  east_avail, north_avail, south_avail;
  logic [1:0] req, gnt;
  logic  pop;
  logic [PACKET_WIDTH-1:0] sel_pkt, east_pkt;

  assign local_dst = dest_decode(local_dout[DX_MSB:DX_LSB], local_dout[DY_MSB:DY_LSB]);
  assign west_dst  = dest_decode(west_dout[DX_MSB:DX_LSB], west_dout[DY_MSB:DY_LSB]);

  // A strobe issued last cycle is not yet visible in *_full, so a
  // destination written last cycle is treated as unavailable.
  assign east_avail  = !east_full && !east_wen_q;
  assign north_avail = !north_full && !north_wen_q;
  assign south_avail = !south_full && !south_wen_q;

  always_comb begin
    local_avail = 1'b1;
    unique case (local_dst)
      DST_EAST:  local_avail = east_avail;
      DST_NORTH: local_avail = north_avail;
      DST_SOUTH: local_avail = south_avail;
      default:   local_avail = 1'b1;
    endcase
  end

  always_comb begin
    west_avail = 1'b1;
    unique case (west_dst)
      DST_EAST:  west_avail = east_avail;
      DST_NORTH: west_avail = north_avail;
      DST_SOUTH: west_avail = south_avail;
      default:   west_avail = 1'b1;
    endcase
  end

  // Requests are masked in reset so no pop can happen in a reset cycle.
  assign req[0] = !reset && !local_empty && local_avail;
  assign req[1] = !reset && !west_empty && west_avail;

  rr_arbiter2 u_arb (
    .clk_i (clk),
    .rst_i (reset),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign local_ren = gnt[0];
  assign west_ren  = gnt[1];
  assign pop       = |gnt;
  assign sel_pkt   = gnt[1] ? west_dout : local_dout;
  assign sel_dst   = gnt[1] ? west_dst : local_dst;

  // dx >= 1 on the EAST path, so the decrement cannot underflow.
  always_comb begin
    east_pkt = sel_pkt;
    east_pkt[DX_MSB:DX_LSB] = sel_pkt[DX_MSB:DX_LSB] - DX_W'(1);
  end

  always_comb begin
    east_wen_d   = pop && (sel_dst == DST_EAST);
    north_wen_d  = pop && (sel_dst == DST_NORTH);
    south_wen_d  = pop && (sel_dst == DST_SOUTH);
    err_drop_d   = pop && (sel_dst == DST_DROP);
    east_dout_d  = east_wen_d ? east_pkt : east_dout_q;
    north_dout_d = north_wen_d ? sel_pkt : north_dout_q;
    south_dout_d = south_wen_d ? sel_pkt : south_dout_q;
    drop_count_d = drop_count_q;
    if (err_drop_d && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      east_dout_q  <= '0;
      north_dout_q <= '0;
      south_dout_q <= '0;
      east_wen_q   <= 1'b0;
      north_wen_q  <= 1'b0;
      south_wen_q  <= 1'b0;
      err_drop_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      east_dout_q  <= east_dout_d;
      north_dout_q <= north_dout_d;
      south_dout_q <= south_dout_d;
      east_wen_q   <= east_wen_d;
      north_wen_q  <= north_wen_d;
      south_wen_q  <= south_wen_d;
      err_drop_q   <= err_drop_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign east_dout  = east_dout_q;
  assign north_dout = north_dout_q;
  assign south_dout = south_dout_q;
  assign east_wen   = east_wen_q;
  assign north_wen  = north_wen_q;
  assign south_wen  = south_wen_q;
  assign err_drop   = err_drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_east_forward.sv
// Directed bench for east_forward. Upstream FWFT buffers are modelled as
// queues; inputs change 1 time unit after the rising edge.
module tb_east_forward;
  import router_pkg::*;

  logic                    clk;
  logic                    reset;
  logic [PACKET_WIDTH-1:0] local_dout, west_dout;
  logic                    local_empty, west_empty;
  logic                    local_ren, west_ren;
  logic [PACKET_WIDTH-1:0] east_dout, north_dout, south_dout;
  logic                    east_wen, north_wen, south_wen;
  logic                    east_full, north_full, south_full;
  logic                    err_drop;
  logic [7:0]              drop_count;

  logic [PACKET_WIDTH-1:0] lq[$];
  logic [PACKET_WIDTH-1:0] wq[$];

  int n_vec;
  int n_err;

  east_forward dut (
    .clk        (clk),
    .reset      (reset),
    .local_dout (local_dout),
    .local_empty(local_empty),
    .local_ren  (local_ren),
    .west_dout  (west_dout),
    .west_empty (west_empty),
    .west_ren   (west_ren),
    .east_dout  (east_dout),
    .east_wen   (east_wen),
    .east_full  (east_full),
    .north_dout (north_dout),
    .north_wen  (north_wen),
    .north_full (north_full),
    .south_dout (south_dout),
    .south_wen  (south_wen),
    .south_full (south_full),
    .err_drop   (err_drop),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PACKET_WIDTH-1:0] mk(input int dx, input int dy,
                                                 input logic [11:0] pl);
    logic [8:0] x;
    logic [8:0] y;
    x = dx[8:0];
    y = dy[8:0];
    return {x, y, pl};
  endfunction

  task automatic refresh();
    local_empty = (lq.size() == 0);
    local_dout  = (lq.size() == 0) ? '0 : lq[0];
    west_empty  = (wq.size() == 0);
    west_dout   = (wq.size() == 0) ? '0 : wq[0];
  endtask

  task automatic settle();
    refresh();
    #1;
  endtask

  // Sample ren before the edge, pop the modelled buffers after it.
  task automatic step();
    logic lp, wp;
    logic [PACKET_WIDTH-1:0] dummy;
    #1;
    lp = local_ren;
    wp = west_ren;
    @(posedge clk);
    #1;
    if (lp && lq.size() > 0) dummy = lq.pop_front();
    if (wp && wq.size() > 0) dummy = wq.pop_front();
    refresh();
    #1;
  endtask

  initial begin
    int cyc;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    east_full = 1'b0;
    north_full = 1'b0;
    south_full = 1'b0;
    refresh();
    step();
    step();

    // Reset state
    check("rst_east_wen", east_wen, 0);
    check("rst_north_wen", north_wen, 0);
    check("rst_south_wen", south_wen, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_east_dout", east_dout, 0);
    check("rst_north_dout", north_dout, 0);
    check("rst_south_dout", south_dout, 0);
    check("rst_local_ren", local_ren, 0);
    check("rst_west_ren", west_ren, 0);
    reset = 1'b0;
    step();

    // Single local packet eastward
    lq.push_back(mk(3, 2, 12'hABC));
    settle();
    check("t1_local_ren", local_ren, 1);
    check("t1_west_ren", west_ren, 0);
    step();
    check("t1_east_wen", east_wen, 1);
    check("t1_east_dout", east_dout, mk(2, 2, 12'hABC));
    check("t1_north_wen", north_wen, 0);
    check("t1_local_ren_idle", local_ren, 0);
    step();
    check("t1_east_wen_1cyc", east_wen, 0);

    // Turn south and north after reset, local wins the tie
    reset = 1'b1;
    step();
    reset = 1'b0;
    lq.push_back(mk(0, -1, 12'h111));
    wq.push_back(mk(0, 5, 12'h222));
    settle();
    check("t2_local_ren", local_ren, 1);
    check("t2_west_ren_lose", west_ren, 0);
    step();
    check("t2_south_wen", south_wen, 1);
    check("t2_south_dout", south_dout, mk(0, -1, 12'h111));
    check("t2_north_wen_0", north_wen, 0);
    check("t2_west_ren", west_ren, 1);
    step();
    check("t2_north_wen", north_wen, 1);
    check("t2_north_dout", north_dout, mk(0, 5, 12'h222));
    check("t2_south_wen_1cyc", south_wen, 0);
    step();
    check("t2_north_wen_1cyc", north_wen, 0);

    // Contention for EAST: alternate grants with a gap cycle
    for (int i = 0; i < 3; i++) begin
      lq.push_back(mk(1, 0, 12'h100 + 12'(i)));
      wq.push_back(mk(1, 0, 12'h200 + 12'(i)));
    end
    settle();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("t3_local_ren_%0d", k), local_ren, (k % 4 == 0));
      check($sformatf("t3_west_ren_%0d", k), west_ren, (k % 4 == 2));
      check($sformatf("t3_east_wen_%0d", k), east_wen, (k % 2 == 1));
      if (k == 3) check("t3_east_dout_w0", east_dout, mk(0, 0, 12'h200));
      step();
    end
    step();

    // East blocked; west still turns north
    east_full = 1'b1;
    lq.push_back(mk(2, 0, 12'h333));
    wq.push_back(mk(0, 0, 12'h444));
    settle();
    check("t4_local_ren_blk", local_ren, 0);
    check("t4_west_ren", west_ren, 1);
    step();
    check("t4_north_wen", north_wen, 1);
    check("t4_north_dout", north_dout, mk(0, 0, 12'h444));
    check("t4_east_wen", east_wen, 0);
    check("t4_local_ren_blk2", local_ren, 0);
    step();
    east_full = 1'b0;
    settle();
    check("t4_local_ren_rel", local_ren, 1);
    step();
    check("t4_east_wen_rel", east_wen, 1);
    check("t4_east_dout", east_dout, mk(1, 0, 12'h333));
    step();

    // Drops and saturating counter
    lq.push_back(mk(-4, 0, 12'h555));
    settle();
    check("t5_local_ren", local_ren, 1);
    step();
    check("t5_err_drop", err_drop, 1);
    check("t5_drop_count", drop_count, 1);
    check("t5_east_wen", east_wen, 0);
    check("t5_north_wen", north_wen, 0);
    check("t5_south_wen", south_wen, 0);
    step();
    check("t5_err_drop_1cyc", err_drop, 0);
    check("t5_drop_count_hold", drop_count, 1);
    for (int i = 0; i < 300; i++) lq.push_back(mk(-4, 0, 12'(i)));
    settle();
    cyc = 0;
    while (lq.size() > 0 && cyc < 400) begin
      step();
      cyc++;
    end
    check("t5_drain", (lq.size() == 0), 1);
    step();
    check("t5_drop_sat", drop_count, 255);
    check("t5_err_drop_end", err_drop, 0);

    // Reset in the cycle after a pop
    lq.push_back(mk(1, 0, 12'h666));
    settle();
    check("t6_local_ren", local_ren, 1);
    step();
    check("t6_east_wen_pre", east_wen, 1);
    reset = 1'b1;
    step();
    check("t6_east_wen_rst", east_wen, 0);
    check("t6_east_dout_rst", east_dout, 0);
    check("t6_drop_count_rst", drop_count, 0);
    check("t6_north_dout_rst", north_dout, 0);
    check("t6_err_drop_rst", err_drop, 0);
    lq.push_back(mk(1, 0, 12'h777));
    wq.push_back(mk(0, 3, 12'h888));
    settle();
    check("t6_local_ren_in_rst", local_ren, 0);
    check("t6_west_ren_in_rst", west_ren, 0);
    step();
    reset = 1'b0;
    settle();
    check("t6_tie_local", local_ren, 1);
    check("t6_tie_west", west_ren, 0);
    step();
    check("t6_east_wen", east_wen, 1);
    check("t6_east_dout", east_dout, mk(0, 0, 12'h777));
    check("t6_west_ren", west_ren, 1);
    step();
    check("t6_north_wen", north_wen, 1);
    check("t6_north_dout", north_dout, mk(0, 3, 12'h888));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
